// File: rtl/wb_arbiter_if.sv
// Writeback arbitration bus: ALU and MEM request channels, stall input and
// the registered register-file write port.
interface wb_arbiter_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          alu_valid;
  logic [DW-1:0] alu_data;
  logic [RW-1:0] alu_rd;
  logic          alu_ready;
  logic          mem_valid;
  logic [DW-1:0] mem_data;
  logic [RW-1:0] mem_rd;
  logic          mem_ready;
  logic          wb_stall;
  logic          vsel;
  logic [DW-1:0] data_in;
  logic [RW-1:0] writenum;
  logic          write;
  logic [1:0]    starve_cnt;

  modport master (
    output alu_valid, alu_data, alu_rd, mem_valid, mem_data, mem_rd, wb_stall,
    input  alu_ready, mem_ready, vsel, data_in, writenum, write, starve_cnt
  );

  modport slave (
    input  alu_valid, alu_data, alu_rd, mem_valid, mem_data, mem_rd, wb_stall,
    output alu_ready, mem_ready, vsel, data_in, writenum, write, starve_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks ALU or MEM result for the register file, MEM first
// with a starvation bound on ALU, one registered output stage.
module wb_arbiter #(
  parameter int DW         = 16,
  parameter int RW         = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WB   = 1'b1
  } state_t;

  localparam logic [1:0] STARVE_MAX_C = 2'(STARVE_MAX);

  state_t        state_r;
  logic [1:0]    starve_r;
  logic          write_r;
  logic          vsel_r;
  logic [DW-1:0] data_r;
  logic [RW-1:0] rd_r;
  logic          gnt_alu_s;
  logic          gnt_mem_s;

  // Grant decision from valids, stall and starvation count only.
  always_comb begin
    gnt_alu_s = 1'b0;
    gnt_mem_s = 1'b0;
    if (reset_n && !bus.wb_stall) begin
      if (bus.alu_valid && (!bus.mem_valid || (starve_r == STARVE_MAX_C))) begin
        gnt_alu_s = 1'b1;
      end else if (bus.mem_valid) begin
        gnt_mem_s = 1'b1;
      end else begin
        gnt_alu_s = 1'b0;
      end
    end else begin
      gnt_alu_s = 1'b0;
    end
  end

  // Starvation counter: saturates while ALU keeps losing, frozen under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_r <= 2'd0;
    end else if (bus.wb_stall) begin
      starve_r <= starve_r;
    end else if (!bus.alu_valid || gnt_alu_s) begin
      starve_r <= 2'd0;
    end else if (starve_r != STARVE_MAX_C) begin
      starve_r <= starve_r + 2'd1;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Writeback FSM; data/rd/vsel only move on a transfer so idle cycles hold them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      write_r <= 1'b0;
      vsel_r  <= 1'b0;
      data_r  <= '0;
      rd_r    <= '0;
    end else begin
      case (state_r)
        IDLE, WB: begin
          if (gnt_alu_s || gnt_mem_s) begin
            state_r <= WB;
            write_r <= 1'b1;
            vsel_r  <= gnt_mem_s;
            data_r  <= gnt_mem_s ? bus.mem_data : bus.alu_data;
            rd_r    <= gnt_mem_s ? bus.mem_rd : bus.alu_rd;
          end else begin
            state_r <= IDLE;
            write_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          write_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_ready  = gnt_alu_s;
  assign bus.mem_ready  = gnt_mem_s;
  assign bus.write      = write_r;
  assign bus.vsel       = vsel_r;
  assign bus.data_in    = data_r;
  assign bus.writenum   = rd_r;
  assign bus.starve_cnt = starve_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle comparison against a behavioural model plus
// hand-computed checkpoints for the directed scenarios.
module tb_wb_arbiter;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int SMAX = 3;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  // model state
  int          m_starve;
  logic        m_write;
  logic        m_vsel;
  logic [15:0] m_data;
  logic [2:0]  m_rd;
  logic        last_alu;
  logic        last_mem;

  wb_arbiter_if #(.DW(DW), .RW(RW)) bus ();

  wb_arbiter #(.DW(DW), .RW(RW), .STARVE_MAX(SMAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare at negedge against the model, advance the model, then
  // return #1 after the posedge so the caller can drive the next inputs.
  task automatic step();
    logic e_alu;
    logic e_mem;
    @(negedge clk);
    e_alu = 1'b0;
    e_mem = 1'b0;
    if (!reset_n) begin
      chk("rst_alu_ready", bus.alu_ready, 0);
      chk("rst_mem_ready", bus.mem_ready, 0);
      chk("rst_write", bus.write, 0);
      chk("rst_data_in", bus.data_in, 0);
      chk("rst_writenum", bus.writenum, 0);
      chk("rst_vsel", bus.vsel, 0);
      chk("rst_starve", bus.starve_cnt, 0);
      m_starve = 0; m_write = 1'b0; m_vsel = 1'b0; m_data = '0; m_rd = '0;
    end else begin
      if (!bus.wb_stall) begin
        if (bus.alu_valid && bus.mem_valid) begin
          if (m_starve == SMAX) e_alu = 1'b1;
          else e_mem = 1'b1;
        end else begin
          e_alu = bus.alu_valid;
          e_mem = bus.mem_valid;
        end
      end
      chk("alu_ready", bus.alu_ready, e_alu);
      chk("mem_ready", bus.mem_ready, e_mem);
      chk("write", bus.write, m_write);
      chk("vsel", bus.vsel, m_vsel);
      chk("data_in", bus.data_in, m_data);
      chk("writenum", bus.writenum, m_rd);
      chk("starve_cnt", bus.starve_cnt, m_starve);
      if (e_alu) begin
        m_write = 1'b1; m_vsel = 1'b0; m_data = bus.alu_data; m_rd = bus.alu_rd;
      end else if (e_mem) begin
        m_write = 1'b1; m_vsel = 1'b1; m_data = bus.mem_data; m_rd = bus.mem_rd;
      end else begin
        m_write = 1'b0;
      end
      if (!bus.wb_stall) begin
        if (!bus.alu_valid || e_alu) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
      end
    end
    last_alu = e_alu;
    last_mem = e_mem;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_sc [8];
    logic       exp_vs [8];
    n_cmp = 0; n_bad = 0;
    m_starve = 0; m_write = 1'b0; m_vsel = 1'b0; m_data = '0; m_rd = '0;
    last_alu = 1'b0; last_mem = 1'b0;
    reset_n = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_data = 16'h0000; bus.alu_rd = 3'd0;
    bus.mem_valid = 1'b0; bus.mem_data = 16'h0000; bus.mem_rd = 3'd0;
    bus.wb_stall = 1'b0;
    #1;
    chk("init_write", bus.write, 0);
    chk("init_starve", bus.starve_cnt, 0);
    step();
    reset_n = 1'b1;

    // single ALU transfer
    bus.alu_valid = 1'b1; bus.alu_data = 16'h1234; bus.alu_rd = 3'd3;
    step();
    chk("alu1_write", bus.write, 1);
    chk("alu1_vsel", bus.vsel, 0);
    chk("alu1_data", bus.data_in, 16'h1234);
    chk("alu1_rd", bus.writenum, 3);
    bus.alu_valid = 1'b0;
    step();
    chk("alu1_write_after", bus.write, 0);
    chk("idle_hold_data", bus.data_in, 16'h1234);

    // both valid continuously: MEM,MEM,MEM,ALU repeating
    exp_sc = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_vs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bus.alu_valid = 1'b1; bus.alu_data = 16'hA000; bus.alu_rd = 3'd1;
    bus.mem_valid = 1'b1; bus.mem_data = 16'hB000; bus.mem_rd = 3'd4;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("starve_seq", bus.starve_cnt, exp_sc[i]);
      chk("vsel_seq", bus.vsel, exp_vs[i]);
      chk("write_seq", bus.write, 1);
      if (last_alu) bus.alu_data = bus.alu_data + 16'd1;
      if (last_mem) bus.mem_data = bus.mem_data + 16'd1;
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    step();

    // MEM held off by stall for two cycles
    bus.mem_valid = 1'b1; bus.mem_data = 16'hBEEF; bus.mem_rd = 3'd5; bus.wb_stall = 1'b1;
    chk("stall_mem_ready", bus.mem_ready, 0);
    step();
    chk("stall_write1", bus.write, 0);
    step();
    chk("stall_write2", bus.write, 0);
    bus.wb_stall = 1'b0;
    #1;
    chk("release_mem_ready", bus.mem_ready, 1);
    step();
    chk("mem_write", bus.write, 1);
    chk("mem_vsel", bus.vsel, 1);
    chk("mem_data", bus.data_in, 16'hBEEF);
    chk("mem_rd", bus.writenum, 5);
    bus.mem_valid = 1'b0;
    step();

    // reset between transfer and write cycle
    bus.alu_valid = 1'b1; bus.alu_data = 16'h5555; bus.alu_rd = 3'd6;
    step();
    reset_n = 1'b0;
    bus.alu_valid = 1'b0;
    #1;
    chk("midrst_write", bus.write, 0);
    chk("midrst_data", bus.data_in, 0);
    chk("midrst_rd", bus.writenum, 0);
    chk("midrst_vsel", bus.vsel, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("postrst_write", bus.write, 0);

    // same destination, ALU then MEM back-to-back
    bus.alu_valid = 1'b1; bus.alu_data = 16'h1111; bus.alu_rd = 3'd2;
    step();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_data = 16'h2222; bus.mem_rd = 3'd2;
    chk("same_rd_w1", bus.write, 1);
    chk("same_rd_v1", bus.vsel, 0);
    chk("same_rd_d1", bus.data_in, 16'h1111);
    chk("same_rd_r1", bus.writenum, 2);
    step();
    bus.mem_valid = 1'b0;
    chk("same_rd_w2", bus.write, 1);
    chk("same_rd_v2", bus.vsel, 1);
    chk("same_rd_d2", bus.data_in, 16'h2222);
    chk("same_rd_r2", bus.writenum, 2);
    step();

    // mixed traffic, sources hold data until accepted
    for (int i = 0; i < 80; i++) begin
      if (!bus.alu_valid || last_alu) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_data = 16'($urandom);
        bus.alu_rd = 3'($urandom);
      end
      if (!bus.mem_valid || last_mem) begin
        bus.mem_valid = ($urandom_range(0, 3) != 0);
        bus.mem_data = 16'($urandom);
        bus.mem_rd = 3'($urandom);
      end
      bus.wb_stall = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0; bus.wb_stall = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DW, 16, data width of register-file write data.
REQ-002 Parameter RW, 3, register-number width.
REQ-003 Parameter STARVE_MAX, 3, max consecutive cycles a valid ALU request may lose to MEM.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 alu_valid  in  1  ALU result pending.
REQ-007 alu_data  in  DW  ALU result (datapath_out side of writeback mux).
REQ-008 alu_rd  in  RW  ALU destination register.
REQ-009 alu_ready  out  1  ALU request accepted this cycle (combinational).
REQ-010 mem_valid  in  1  memory load data pending.
REQ-011 mem_data  in  DW  load data (datapath_in side of writeback mux).
REQ-012 mem_rd  in  RW  load destination register.
REQ-013 mem_ready  out  1  MEM request accepted this cycle (combinational).
REQ-014 wb_stall  in  1  register file cannot take a write this cycle.
REQ-015 vsel  out  1  writeback mux select; 1 = memory data, 0 = ALU data.
REQ-016 data_in  out  DW  registered write data to register file.
REQ-017 writenum  out  RW  registered destination register.
REQ-018 write  out  1  register-file write enable.
REQ-019 starve_cnt  out  2  current ALU starvation count (debug/observability).

Function
REQ-020 Handshake: a transfer occurs on a source when valid && ready at posedge clk; the source SHALL hold data/rd stable while valid && !ready.
REQ-021 At most one of alu_ready, mem_ready SHALL be 1 in any cycle; both 0 when wb_stall=1 or no valid.
REQ-022 Grant rule (wb_stall=0): only one valid -> grant it; both valid -> grant MEM unless starve_cnt == STARVE_MAX, then grant ALU.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) when alu_valid=1 and ALU not granted and wb_stall=0; clear to 0 when ALU granted or alu_valid=0; hold while wb_stall=1.
REQ-024 Latency: a transfer in cycle N SHALL produce write=1, data_in, writenum, vsel of that source in cycle N+1 (one registered stage).
REQ-025 State machine: IDLE (write=0) and WB (write=1); IDLE->WB on any transfer; WB->WB on transfer; WB->IDLE when no transfer; any->IDLE with write=0 when wb_stall=1 and no transfer.
REQ-026 While wb_stall=1, data_in, writenum, vsel SHALL hold previous values and write SHALL be 0 the next cycle.
REQ-027 In IDLE, data_in, writenum, vsel SHALL hold last written values (no spurious toggling).
REQ-028 Back-to-back transfers SHALL sustain one register write per cycle with no bubble.
REQ-029 Same destination register on consecutive writes SHALL be written in grant order; no merging or dropping.
REQ-030 alu_ready/mem_ready SHALL depend only on current valids, wb_stall and starve_cnt (no combinational path from data/rd).

Reset
REQ-031 reset_n=0 SHALL immediately force write=0, vsel=0, data_in=0, writenum=0, starve_cnt=0, state IDLE, regardless of clk.
REQ-032 While reset_n=0, alu_ready=mem_ready=0.
REQ-033 Reset asserted mid-transfer SHALL discard the in-flight write; first grant possible on first posedge after reset_n rises.

Verification
REQ-034 Reset then alu_valid=1, alu_data=16'h1234, alu_rd=3 one cycle -> next cycle write=1, vsel=0, data_in=16'h1234, writenum=3; following cycle write=0.
REQ-035 Both valid continuously, STARVE_MAX=3 -> grants MEM,MEM,MEM,ALU,MEM,MEM,MEM,ALU...; starve_cnt 1,2,3,0 repeating; write=1 every cycle.
REQ-036 mem_valid=1, mem_data=16'hBEEF, mem_rd=5 with wb_stall=1 for 2 cycles -> mem_ready=0 both cycles, write=0; on stall release mem_ready=1, next cycle write=1, vsel=1, data_in=16'hBEEF, writenum=5.
REQ-037 reset_n pulsed low between transfer and write cycle -> write stays 0, all outputs 0, no write issued after reset.
REQ-038 Alternating ALU rd=2 then MEM rd=2 back-to-back -> two writes to writenum=2 in grant order, vsel 0 then 1.
